// File: rtl/rx_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_sched_pkg                                                         |
// | Shared state encoding and constants for the RX capture scheduler.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rx_sched_pkg;

  localparam int c_en_width                = 4;
  localparam int c_default_reconfig_cycles = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECONFIG = 2'd1,
    ST_ARMED    = 2'd2,
    ST_STREAM   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rx_burst_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_burst_counter                                                     |
// | Loadable sample counter; terminal flags the strobe reaching target.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_burst_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_target,
  input  logic                 clear,
  input  logic                 inc,
  output logic                 terminal
);

  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_target;
  logic [CNT_WIDTH-1:0] w_count_next;

  assign w_count_next = r_count + 1'b1;
  // A zero target means continuous mode, which never terminates.
  assign terminal     = (r_target != '0) && (w_count_next == r_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_target <= '0;
    end else begin
      if (load) begin
        r_target <= load_target;
      end
      if (clear) begin
        r_count <= '0;
      end else if (inc) begin
        r_count <= w_count_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_capture_scheduler                                                 |
// | Sequences capture commands into the timestamping channel packer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_capture_scheduler
  import rx_sched_pkg::*;
#(
  parameter int TS_WIDTH        = 64,
  parameter int CNT_WIDTH       = 32,
  parameter int RECONFIG_CYCLES = c_default_reconfig_cycles,
  parameter int OVF_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TS_WIDTH-1:0]      timestamp,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [c_en_width-1:0]    cmd_enables,
  input  logic                     cmd_immediate,
  input  logic [TS_WIDTH-1:0]      cmd_start_time,
  input  logic [CNT_WIDTH-1:0]     cmd_num_samples,
  input  logic                     abort,
  input  logic                     adc_valid,
  output logic                     pack_wr_en,
  output logic [c_en_width-1:0]    pack_enable,
  output logic                     pack_reset,
  input  logic                     pack_overflow,
  output logic                     busy,
  output logic                     done,
  output logic                     late,
  output logic                     cmd_error,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

  localparam int c_rc_w = (RECONFIG_CYCLES > 2) ? $clog2(RECONFIG_CYCLES) : 1;
  localparam logic [c_rc_w-1:0] c_rc_last = c_rc_w'(RECONFIG_CYCLES - 1);

  state_t                   r_state, w_state_next;
  logic [c_en_width-1:0]    r_enables;
  logic                     r_immediate;
  logic [TS_WIDTH-1:0]      r_start_time;
  logic [c_rc_w-1:0]        r_rc_cnt;
  logic                     r_armed_first;
  logic                     r_post_reset;
  logic                     r_done, r_late, r_cmd_error;
  logic [OVF_CNT_WIDTH-1:0] r_ovf_count;
  logic                     r_ovf_prev;

  logic w_accept, w_reject, w_wr_en, w_inc, w_done_set, w_late_set, w_terminal;
  logic w_start_ok;

  assign w_start_ok = r_immediate || (timestamp >= r_start_time);

  rx_burst_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_burst_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (w_accept),
    .load_target (cmd_num_samples),
    .clear       (w_accept),
    .inc         (w_inc),
    .terminal    (w_terminal)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_wr_en      = 1'b0;
    w_inc        = 1'b0;
    w_done_set   = 1'b0;
    w_late_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_enables == '0) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = ST_RECONFIG;
          end
        end
      end
      ST_RECONFIG: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (r_rc_cnt == c_rc_last) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Lateness is judged only on the first armed cycle.
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (r_armed_first && !r_immediate && (timestamp > r_start_time)) begin
          w_late_set   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (adc_valid && w_start_ok) begin
          w_wr_en      = 1'b1;
          w_inc        = 1'b1;
          w_done_set   = w_terminal;
          w_state_next = w_terminal ? ST_IDLE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (adc_valid) begin
          w_wr_en    = 1'b1;
          w_inc      = 1'b1;
          w_done_set = w_terminal;
          if (w_terminal) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rc_cnt      <= '0;
      r_armed_first <= 1'b0;
      r_post_reset  <= 1'b1;
      r_done        <= 1'b0;
      r_late        <= 1'b0;
      r_cmd_error   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rc_cnt      <= (r_state == ST_RECONFIG) ? r_rc_cnt + 1'b1 : '0;
      r_armed_first <= (r_state == ST_RECONFIG) && (w_state_next == ST_ARMED);
      r_post_reset  <= 1'b0;
      r_done        <= w_done_set;
      r_late        <= w_late_set;
      r_cmd_error   <= w_reject;
    end
  end

  // Command fields; enables persist across captures so the packer keeps its setup.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enables    <= '0;
      r_immediate  <= 1'b0;
      r_start_time <= '0;
    end else if (w_accept) begin
      r_enables    <= cmd_enables;
      r_immediate  <= cmd_immediate;
      r_start_time <= cmd_start_time;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_prev  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      r_ovf_prev <= pack_overflow;
      if (w_accept) begin
        r_ovf_count <= '0;
      end else if ((r_state == ST_STREAM) && pack_overflow && !r_ovf_prev &&
                   (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign pack_wr_en  = w_wr_en;
  assign pack_enable = r_enables;
  assign pack_reset  = r_post_reset || (r_state == ST_RECONFIG);
  assign done        = r_done;
  assign late        = r_late;
  assign cmd_error   = r_cmd_error;
  assign ovf_count   = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_capture_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_capture_scheduler                                              |
// | Randomized scoreboard bench with a transaction-level capture model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rx_capture_scheduler;

  localparam int c_rc  = 4;
  localparam int c_len = 150;
  localparam int K_PRST = 0, K_STRB = 1, K_DONE = 2, K_LATE = 3, K_ERR = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] timestamp = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_enables = '0;
  logic        cmd_immediate = 1'b0;
  logic [63:0] cmd_start_time = '0;
  logic [31:0] cmd_num_samples = '0;
  logic        abort = 1'b0;
  logic        adc_valid = 1'b0;
  logic        pack_wr_en;
  logic [3:0]  pack_enable;
  logic        pack_reset;
  logic        pack_overflow = 1'b0;
  logic        busy, done, late, cmd_error;
  logic [2:0]  ovf_count;

  always #5 clk = ~clk;

  rx_capture_scheduler #(
    .TS_WIDTH        (64),
    .CNT_WIDTH       (32),
    .RECONFIG_CYCLES (c_rc),
    .OVF_CNT_WIDTH   (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .timestamp       (timestamp),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_enables     (cmd_enables),
    .cmd_immediate   (cmd_immediate),
    .cmd_start_time  (cmd_start_time),
    .cmd_num_samples (cmd_num_samples),
    .abort           (abort),
    .adc_valid       (adc_valid),
    .pack_wr_en      (pack_wr_en),
    .pack_enable     (pack_enable),
    .pack_reset      (pack_reset),
    .pack_overflow   (pack_overflow),
    .busy            (busy),
    .done            (done),
    .late            (late),
    .cmd_error       (cmd_error),
    .ovf_count       (ovf_count)
  );

  typedef struct {
    int              kind;
    longint unsigned ts;
    logic [3:0]      en;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_on = 1'b0;
  logic [3:0] last_en = '0;
  bit         adc_pat[0:c_len];

  function automatic string kname(int k);
    case (k)
      K_PRST:  return "pack_reset";
      K_STRB:  return "strobe";
      K_DONE:  return "done";
      K_LATE:  return "late";
      default: return "cmd_error";
    endcase
  endfunction

  task automatic observe(int k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s at ts=%0d en=%h, required none",
               kname(k), timestamp, pack_enable);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.ts != timestamp || (k == K_STRB && e.en != pack_enable)) begin
        n_bad++;
        $display("FAIL event: got %s ts=%0d en=%h, required %s ts=%0d en=%h",
                 kname(k), timestamp, pack_enable, kname(e.kind), e.ts, e.en);
      end
    end
  endtask

  // Monitor: every DUT-visible event is matched against the expected queue.
  always @(negedge clk) begin
    if (mon_on) begin
      if (pack_reset) observe(K_PRST);
      if (pack_wr_en) observe(K_STRB);
      if (done)       observe(K_DONE);
      if (late)       observe(K_LATE);
      if (cmd_error)  observe(K_ERR);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    timestamp = timestamp + 64'd1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(int k, longint unsigned ts, logic [3:0] en);
    ev_t e;
    e.kind = k;
    e.ts   = ts;
    e.en   = en;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("idle_wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic issue(logic [3:0] en, bit imm, longint unsigned start, int num);
    cmd_valid       = 1'b1;
    cmd_enables     = en;
    cmd_immediate   = imm;
    cmd_start_time  = start;
    cmd_num_samples = 32'(num);
    adc_valid       = 1'b0;
    abort           = 1'b0;
  endtask

  // Model: first qualifying strobes after the reconfig window, cut by count or abort.
  task automatic run_capture(logic [3:0] en, bit imm, longint unsigned start, int num,
                             int mode, int abort_k);
    longint unsigned a, armed, term, abort_at;
    int c;
    bit fin;
    a        = timestamp;
    abort_at = 0;
    for (int j = 0; j <= c_len; j++) begin
      case (mode)
        0:       adc_pat[j] = 1'b1;
        1:       adc_pat[j] = (j % 2 == 0);
        2:       adc_pat[j] = ($urandom_range(0, 3) != 0);
        default: adc_pat[j] = ($urandom_range(0, 3) == 0);
      endcase
    end
    issue(en, imm, start, num);
    if (en == 4'd0) begin
      push(K_ERR, a + 1, 4'd0);
      term = a + 1;
    end else begin
      last_en = en;
      for (longint unsigned w = a + 1; w <= a + c_rc; w++) push(K_PRST, w, en);
      armed = a + 1 + c_rc;
      if (!imm && armed > start) begin
        push(K_LATE, armed + 1, en);
        term = armed + 1;
      end else begin
        c           = 0;
        fin         = 1'b0;
        abort_at    = a + c_len + 1;
        adc_pat[c_len] = 1'b0;
        term        = abort_at;
        for (longint unsigned w = armed; w <= a + c_len && !fin; w++) begin
          if (adc_pat[int'(w - a - 1)] && (imm || w >= start)) begin
            c++;
            if (abort_k >= 0 && c == abort_k + 1) begin
              abort_at = w;
              term     = w;
              fin      = 1'b1;
            end else begin
              push(K_STRB, w, en);
              if (num != 0 && c == num) begin
                push(K_DONE, w + 1, en);
                abort_at = 0;
                term     = w + 1;
                fin      = 1'b1;
              end
            end
          end
        end
      end
    end
    step();
    cmd_valid = 1'b0;
    for (longint unsigned w = a + 1; w <= term + 2; w++) begin
      adc_valid = (w - a - 1 <= c_len) ? adc_pat[int'(w - a - 1)] : 1'b0;
      abort     = (abort_at != 0 && w == abort_at);
      step();
    end
    adc_valid = 1'b0;
    abort     = 1'b0;
    chk("missing_events", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("pack_enable_held", 64'(pack_enable), 64'(last_en));
    chk("ready_after_capture", 64'(cmd_ready), 64'd1);
  endtask

  task automatic ovf_pulses(int n);
    repeat (n) begin
      pack_overflow = 1'b1;
      step();
      step();
      pack_overflow = 1'b0;
      step();
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned a, armed;
    int off, dcnt, wcnt;

    repeat (3) step();
    chk("rst_cmd_ready",  64'(cmd_ready),  64'd1);
    chk("rst_pack_wr_en", 64'(pack_wr_en), 64'd0);
    chk("rst_pack_enable",64'(pack_enable),64'd0);
    chk("rst_pack_reset", 64'(pack_reset), 64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_pulses",     64'({done, late, cmd_error}), 64'd0);
    chk("rst_ovf_count",  64'(ovf_count),  64'd0);
    reset = 1'b0;
    step();
    chk("pack_reset_cleared", 64'(pack_reset), 64'd0);
    mon_on = 1'b1;

    // Late start: start 50, accepted at 100.
    while (timestamp < 100) step();
    run_capture(4'b0110, 1'b0, 50, 4, 0, -1);

    // Timed start: accept at 985, reconfig 986..989, strobes 1000..1007.
    while (timestamp < 985) step();
    run_capture(4'b0011, 1'b0, 1000, 8, 0, -1);
    chk("timed_pack_enable", 64'(pack_enable), 64'd3);

    // Continuous with abort coincident with the 21st strobe.
    run_capture(4'b1001, 1'b1, 0, 0, 1, 20);

    // Rejected command keeps the previous enables.
    run_capture(4'b0000, 1'b0, 0, 5, 2, -1);

    for (int i = 0; i < 30; i++) begin
      wait_idle();
      off = int'($urandom_range(0, 30)) - 5;
      run_capture(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  longint'(timestamp) + 1 + c_rc + off, int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    // Overflow counting and saturation (3-bit counter).
    wait_idle();
    a     = timestamp;
    armed = a + 1 + c_rc;
    issue(4'hF, 1'b1, 0, 0);
    last_en = 4'hF;
    for (longint unsigned w = a + 1; w <= a + c_rc; w++) push(K_PRST, w, 4'hF);
    push(K_STRB, armed, 4'hF);
    step();
    cmd_valid = 1'b0;
    for (longint unsigned w = a + 1; w <= armed; w++) begin
      adc_valid = (w == armed);
      step();
    end
    adc_valid = 1'b0;
    ovf_pulses(3);
    chk("ovf_count_3", 64'(ovf_count), 64'd3);
    ovf_pulses(6);
    chk("ovf_count_saturated", 64'(ovf_count), 64'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("ovf_abort_idle", 64'(busy), 64'd0);
    chk("missing_events", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    ovf_pulses(2);
    chk("ovf_held_in_idle", 64'(ovf_count), 64'd7);
    run_capture(4'b0000, 1'b0, 0, 3, 0, -1);
    chk("ovf_held_after_reject", 64'(ovf_count), 64'd7);
    wait_idle();
    run_capture(4'b0010, 1'b1, 0, 1, 0, -1);
    chk("ovf_cleared_on_accept", 64'(ovf_count), 64'd0);

    // Reset after 5 of 16 samples.
    wait_idle();
    a     = timestamp;
    armed = a + 1 + c_rc;
    issue(4'b0101, 1'b1, 0, 16);
    last_en = 4'b0101;
    for (longint unsigned w = a + 1; w <= a + c_rc; w++) push(K_PRST, w, 4'b0101);
    for (longint unsigned w = armed; w < armed + 5; w++) push(K_STRB, w, 4'b0101);
    step();
    cmd_valid = 1'b0;
    adc_valid = 1'b1;
    while (timestamp < armed + 5) step();
    mon_on = 1'b0;
    reset  = 1'b1;
    step();
    chk("mid_reset_events", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("mid_reset_wr_en",      64'(pack_wr_en),  64'd0);
    chk("mid_reset_pack_reset", 64'(pack_reset),  64'd1);
    chk("mid_reset_busy",       64'(busy),        64'd0);
    chk("mid_reset_enable",     64'(pack_enable), 64'd0);
    step();
    reset = 1'b0;
    dcnt  = 0;
    wcnt  = 0;
    repeat (12) begin
      step();
      if (done) dcnt++;
      if (pack_wr_en) wcnt++;
    end
    chk("mid_reset_no_done",   64'(dcnt), 64'd0);
    chk("mid_reset_no_strobe", 64'(wcnt), 64'd0);
    adc_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_capture_scheduler.md
Name: rx_capture_scheduler

Overview:
- Sequences the RX sample path into the timestamping channel packer.
- Accepts one capture command at a time: channel enables, start time or immediate start, and sample count.
- Reconfigures and resets the packer, waits for the start time, then gates ADC sample strobes into the packer for exactly N samples, or continuously until abort.
- Reports done, late-start, rejected-command and packer-overflow status to the control plane.

Parameters:
- TS_WIDTH, 64, timestamp and start-time width.
- CNT_WIDTH, 32, sample-count width.
- RECONFIG_CYCLES, 4, cycles pack_reset is held after enables change (≥2; covers packer enable-change detection).
- OVF_CNT_WIDTH, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- timestamp  in  TS_WIDTH  free-running sample-clock timestamp, unsigned.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_enables  in  4  channel enables for the capture.
- cmd_immediate  in  1  1 = start at the first sample, ignore start time.
- cmd_start_time  in  TS_WIDTH  first-sample timestamp.
- cmd_num_samples  in  CNT_WIDTH  samples to pass; 0 = continuous.
- abort  in  1  terminate the capture.
- adc_valid  in  1  per-sample strobe from the ADC interface.
- pack_wr_en  out  1  gated sample strobe to the packer.
- pack_enable  out  4  enables driven to the packer.
- pack_reset  out  1  packer reset.
- pack_overflow  in  1  packer overflow flag.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse, burst complete.
- late  out  1  one-cycle pulse, start time already passed.
- cmd_error  out  1  one-cycle pulse, command rejected (enables==0).
- ovf_count  out  OVF_CNT_WIDTH  overflow events in the current capture.

Behaviour:
- Reset values:
  - State IDLE, cmd_ready=1.
  - pack_wr_en=0, pack_enable=0, pack_reset=1 (cleared on the first cycle after reset).
  - done, late, cmd_error = 0; ovf_count=0; busy=0.
- States:
  - IDLE:
    - cmd_ready=1.
    - On accept with cmd_enables==0: cmd_error pulses the next cycle, stay IDLE.
    - On accept otherwise: latch all cmd fields, clear ovf_count and the sample counter, go RECONFIG.
  - RECONFIG:
    - pack_enable = latched enables; pack_reset=1 for RECONFIG_CYCLES cycles; then ARMED.
  - ARMED:
    - On the first cycle only, if !immediate and timestamp > start_time: late pulse, go IDLE; no samples are passed.
    - Otherwise the first cycle with adc_valid and (immediate or timestamp ≥ start_time) passes that sample (pack_wr_en=1 the same cycle), counts it, and goes STREAM. If num_samples==1, go IDLE with done instead.
  - STREAM:
    - pack_wr_en = adc_valid, combinational, zero latency.
    - Each strobe increments the count.
    - When the strobe taking the count to num_samples occurs, done pulses the next cycle and the state goes IDLE.
    - num_samples==0: never completes; runs until abort.
- abort:
  - Any non-IDLE state goes to IDLE next cycle; no done pulse.
  - pack_wr_en is forced 0 in the abort cycle itself.
  - pack_enable is held.
- pack_enable holds its last value in IDLE; the packer retains its configuration between captures.
- ovf_count:
  - Increments on each rising edge of pack_overflow while in STREAM.
  - Saturates at all-ones; does not wrap.
  - Held until the next command is accepted.
- Comparisons are unsigned, full TS_WIDTH; timestamp wrap is not handled.
- Sample counter is CNT_WIDTH bits; in continuous mode it is allowed to wrap and is unused.
- Simultaneous events:
  - abort with the final strobe: abort wins; strobe suppressed, no done.
  - abort with cmd_valid in IDLE: command accepted.
  - reset mid-capture: immediate return to reset values, pack_reset asserted.
- cmd_ready=0 in every state except IDLE.

Decomposition:
- Shared package rx_sched_pkg holds:
  - state enum (IDLE, RECONFIG, ARMED, STREAM);
  - default RECONFIG_CYCLES;
  - enable-mask width constant (4).
- One sub-module, rx_burst_counter:
  - loadable CNT_WIDTH counter with clear, increment, and a terminal flag (count+1 == target, target≠0);
  - instantiated once.

Test Plan:
- Timed start: cmd enables=4'b0011, start_time=1000, num=8; adc_valid every cycle, timestamp=cycle → pack_reset high 4 cycles; first pack_wr_en at ts=1000; exactly 8 strobes; done one cycle after the 8th; pack_enable=3.
- Late start: start_time=50, accepted at ts=100 → late pulse; zero pack_wr_en strobes; back in IDLE with cmd_ready=1.
- Continuous plus abort: immediate, num=0, adc_valid every 2nd cycle; abort after 20 strobes, coincident with a strobe → that strobe suppressed; 20 strobes total; no done.
- Rejected command: enables=0 → cmd_error pulse; state stays IDLE; pack_enable unchanged.
- Overflow counting: during STREAM toggle pack_overflow high 3 separate times → ovf_count=3; new command → ovf_count=0.
- Reset mid-STREAM: assert reset after 5 of 16 samples → pack_wr_en=0 immediately; pack_reset=1; busy=0; no done.
